stream_width_packer: RTL and testbench
======================================

# stream_width_packer

Packs a valid/ready stream of narrow `DATA_WIDTH` beats into wide words of `RATIO` beats each. A beat flagged `in_last` closes the word early and marks it with a lane mask. The block sits directly downstream of the stream pipeline register and consumes its `out_valid`/`out_ready`/`out_data` stream. It feeds wide datapaths such as the memory write path and wide FIFOs. Its output is fully registered and it sustains one input beat per cycle with no bubbles.

## Interface
- `DATA_WIDTH`, 32, width of one input beat in bits.
- `RATIO`, 4, beats per output word; legal values are ≥ 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: upstream beat available.
- `in_ready` output 1: block can accept a beat this cycle.
- `in_data` input `DATA_WIDTH`: beat payload.
- `in_last` input 1: beat is the final beat of a packet.
- `out_valid` output 1: wide word available.
- `out_ready` input 1: downstream accepts the word.
- `out_data` output `DATA_WIDTH*RATIO`: packed word.
- `out_keep` output `RATIO`: bit k set when lane k holds a valid beat.
- `out_last` output 1: word contains the packet's final beat.

## Operation
- Internal state:
  - Lane index `idx`, counting 0..`RATIO`-1, width `$clog2(RATIO)`.
  - Accumulation registers for data, keep and last.
  - `out_valid` flag.
- The outputs `out_data`, `out_keep` and `out_last` are the accumulation registers, driven directly.
- Two states:
  - COLLECT (`out_valid`=0): beats are written into lanes.
  - HOLD (`out_valid`=1): the word is presented downstream.
- `in_ready` = !`out_valid` || `out_ready` (combinational, no dependence on `in_valid`).
- Input fire = `in_valid` && `in_ready`. Output fire = `out_valid` && `out_ready`.
- Lane order: beat k of a word lands in lane k, bits [k*`DATA_WIDTH` +: `DATA_WIDTH`]. Lane 0 is the first beat, at the LSBs.
- Input fire in COLLECT:
  - Write `in_data` into lane `idx`, set `keep[idx]`.
  - If `idx`==`RATIO`-1 or `in_last`=1: go to HOLD, set `out_last`=`in_last`, reset `idx` to 0.
  - Otherwise increment `idx`.
- Output fire with no input fire: clear data, keep and last to 0, go to COLLECT.
- Output fire and input fire in the same cycle: start a new word.
  - Data is 0 except lane 0 = `in_data`; keep = 1 (lane 0 only).
  - If `in_last`=1 or `RATIO` word completes: stay in HOLD with `out_last`=`in_last`, `idx`=0.
  - Otherwise: go to COLLECT, `idx`=1, `out_last`=0.
- Unused lanes of a short (early-closed) word read as zero.
- `out_keep` is always contiguous from lane 0.
- HOLD without `out_ready`: `out_data`, `out_keep` and `out_last` remain stable; `in_ready`=0.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `idx`=0.
  - `in_ready` therefore reads 1 while in reset and after it.
- Reset release is synchronised externally; the block takes no special release action.
- Reset asserted mid-word or mid-HOLD discards the partial or held word; no output fire occurs.
- Latency: `out_valid` rises in the cycle after the completing beat's input fire.
- Throughput: one beat per cycle sustained while `out_ready` is held at 1.
  - A full word emits every `RATIO` cycles.
  - A single-beat packet can emit every cycle.
- Back-pressure: input stalls only while HOLD and `out_ready`=0. No combinational path from `in_valid` or `in_data` to any output.
- `in_last` is sampled only on input fire; the block ignores it otherwise.

## Test plan
- Full words: `DATA_WIDTH`=32, `RATIO`=4. Send beats 0x11,0x22,0x33,0x44 on consecutive cycles, `out_ready`=1.
  - Required: `out_valid` 1 cycle after the 4th beat, `out_data`=0x00000044_00000033_00000022_00000011, `out_keep`=4'b1111, `out_last`=0.
- Early close: beats 0xA, 0xB with `in_last` on 0xB.
  - Required: `out_data`=0x..._0000000B_0000000A with upper lanes 0, `out_keep`=4'b0011, `out_last`=1. The next word starts at lane 0.
- Back-pressure: complete a word, hold `out_ready`=0 for 5 cycles with `in_valid`=1.
  - Required: `in_ready`=0, `out_*` unchanged for all 5 cycles, no beat lost.
  - On releasing `out_ready`, the pending beat lands in lane 0 in the same cycle the old word fires.
- Back-to-back single-beat packets: `in_last`=1 on every beat, `out_ready`=1.
  - Required: one output per cycle, each with `out_keep`=4'b0001 and `out_last`=1.
- Last on final lane: 4 beats with `in_last` on beat 4.
  - Required: `out_keep`=4'b1111, `out_last`=1.
- Reset mid-word: accept 2 beats, pulse `rst_n` low asynchronously between edges.
  - Required: outputs and `idx` go to 0 immediately, `in_ready`=1.
  - The next 4 beats produce a clean word with lanes in order.

Source files
------------

// File: rtl/stream_width_packer.sv
// Narrow-to-wide stream packer: gathers RATIO beats (or fewer on in_last)
// into one registered wide word with a lane-valid mask.
module stream_width_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last
);

    localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(RATIO - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                        state, state_nx;
    logic [IW-1:0]                 idx, idx_nx;
    logic [DATA_WIDTH*RATIO-1:0]   data_q, data_nx;
    logic [RATIO-1:0]              keep_q, keep_nx;
    logic                          last_q, last_nx;
    logic                          in_fire;
    logic                          out_fire;

    assign out_valid = (state == HOLD);
    assign in_ready  = (state == COLLECT) || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;

    // State and accumulation registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= COLLECT;
            idx    <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            data_q <= data_nx;
            keep_q <= keep_nx;
            last_q <= last_nx;
        end
    end

    // Next-state: lane writes, word close, and same-cycle drain-and-refill.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        data_nx  = data_q;
        keep_nx  = keep_q;
        last_nx  = last_q;

        if (out_fire && in_fire) begin
            // Old word leaves while the new beat opens the next word in lane 0.
            data_nx                 = '0;
            data_nx[DATA_WIDTH-1:0] = in_data;
            keep_nx                 = RATIO'(1);
            last_nx                 = in_last;
            if (in_last) begin
                state_nx = HOLD;
                idx_nx   = '0;
            end else begin
                state_nx = COLLECT;
                idx_nx   = IW'(1);
            end
        end else if (out_fire) begin
            data_nx  = '0;
            keep_nx  = '0;
            last_nx  = 1'b0;
            state_nx = COLLECT;
            idx_nx   = '0;
        end else if (in_fire) begin
            for (int k = 0; k < RATIO; k++) begin
                if (idx == IW'(k)) begin
                    data_nx[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    keep_nx[k]                          = 1'b1;
                end
            end
            if (idx == IDX_MAX || in_last) begin
                state_nx = HOLD;
                last_nx  = in_last;
                idx_nx   = '0;
            end else begin
                idx_nx = idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_width_packer.sv
// Bench for stream_width_packer: directed plan cases plus random traffic
// against a beat-queue reference model.
module tb_stream_width_packer;

    localparam int DW = 32;
    localparam int R  = 4;
    localparam int WW = DW * R;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic [R-1:0]  out_keep;
    logic          out_last;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: beats of the word being collected, plus the word on offer.
    logic [DW-1:0] cur[$];
    bit            hv;
    logic [WW-1:0] hd;
    logic [R-1:0]  hk;
    bit            hl;

    stream_width_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WW-1:0] got,
                         input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] pack(input logic [DW-1:0] q[$]);
        logic [WW-1:0] w = '0;
        for (int k = 0; k < q.size(); k++) w[k*DW +: DW] = q[k];
        return w;
    endfunction

    function automatic logic [R-1:0] keep_of(input int n);
        return R'((1 << n) - 1);
    endfunction

    task automatic model_reset();
        cur.delete();
        hv = 0;
        hd = '0;
        hk = '0;
        hl = 0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance model.
    task automatic cycle(input bit v, input logic [DW-1:0] d,
                         input bit l, input bit r);
        bit exp_rdy, ifire, ofire;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        exp_rdy = !hv || r;
        check("in_ready", WW'(in_ready), WW'(exp_rdy));
        check("out_valid", WW'(out_valid), WW'(hv));
        check("out_data", out_data, hv ? hd : pack(cur));
        check("out_keep", WW'(out_keep), WW'(hv ? hk : keep_of(cur.size())));
        check("out_last", WW'(out_last), WW'(hv ? hl : 1'b0));
        ofire = hv && r;
        ifire = v && exp_rdy;
        if (ofire) hv = 0;
        if (ifire) begin
            cur.push_back(d);
            if (cur.size() == R || l) begin
                hd = pack(cur);
                hk = keep_of(cur.size());
                hl = l;
                hv = 1;
                cur.delete();
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", WW'(out_valid), '0);
        check("rst_ready", WW'(in_ready), WW'(1'b1));
        check("rst_data", out_data, '0);
        check("rst_keep", WW'(out_keep), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full word
        cycle(1, 32'h11, 0, 1);
        cycle(1, 32'h22, 0, 1);
        cycle(1, 32'h33, 0, 1);
        cycle(1, 32'h44, 0, 1);
        cycle(0, 0, 0, 0);
        check("full_data", out_data,
              128'h00000044_00000033_00000022_00000011);
        check("full_keep", WW'(out_keep), WW'(4'b1111));
        check("full_last", WW'(out_last), '0);
        cycle(0, 0, 0, 1);

        // Early close
        cycle(1, 32'hA, 0, 1);
        cycle(1, 32'hB, 1, 1);
        cycle(0, 0, 0, 0);
        check("early_data", out_data, 128'h0000000B_0000000A);
        check("early_keep", WW'(out_keep), WW'(4'b0011));
        check("early_last", WW'(out_last), WW'(1'b1));
        cycle(0, 0, 0, 1);

        // Back-pressure with a pending beat
        for (int i = 1; i <= 4; i++) cycle(1, DW'(i), 0, 1);
        repeat (5) cycle(1, 32'h55, 0, 0);
        cycle(1, 32'h55, 0, 1);
        cycle(0, 0, 0, 0);
        check("bp_lane0", out_data, 128'h55);
        check("bp_keep", WW'(out_keep), WW'(4'b0001));
        cycle(1, 32'h66, 1, 1);
        cycle(0, 0, 0, 1);

        // Back-to-back single-beat packets
        for (int i = 0; i < 6; i++) cycle(1, DW'(32'h100 + i), 1, 1);
        check("single_keep", WW'(out_keep), WW'(4'b0001));
        check("single_valid", WW'(out_valid), WW'(1'b1));
        cycle(0, 0, 0, 1);

        // Last on final lane
        for (int i = 0; i < 4; i++) cycle(1, DW'(32'h200 + i), i == 3, 1);
        cycle(0, 0, 0, 0);
        check("lastfin_keep", WW'(out_keep), WW'(4'b1111));
        check("lastfin_last", WW'(out_last), WW'(1'b1));
        cycle(0, 0, 0, 1);

        // Asynchronous reset mid-word
        cycle(1, 32'hDEAD0001, 0, 1);
        cycle(1, 32'hDEAD0002, 0, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_data", out_data, '0);
        check("mid_rst_keep", WW'(out_keep), '0);
        check("mid_rst_ready", WW'(in_ready), WW'(1'b1));
        check("mid_rst_valid", WW'(out_valid), '0);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) cycle(1, DW'(32'hC0 + i), 0, 1);
        cycle(0, 0, 0, 0);
        check("post_rst_data", out_data,
              128'h000000C3_000000C2_000000C1_000000C0);
        cycle(0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 75, $urandom,
                  $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 70);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
